// File: rtl/cpu_types_pkg.sv
// Types shared by the CPU memory-side blocks: RAM status encoding and data word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between icache (read-only) and dcache (read/write).
// Dcache has priority; a streak counter forces an icache grant once the dcache
// has completed MAX_D_STREAK accesses in a row while the icache was waiting.
// State is registered; RAM-side and cache-side outputs decode combinationally
// from state, so a grant tracks the owner's inputs within the same cycle.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned STREAK_W     = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ramerr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } arb_state_t;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state;
  logic [STREAK_W-1:0] streak;
  ramstate_t           rs;
  logic                dreq;
  logic                i_starved;

  assign rs        = ramstate_t'(ramstate);
  assign dreq      = dREN | dWEN;
  assign i_starved = iREN && (streak == STREAK_MAX);

  // Grant sequencing and dcache streak bookkeeping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !i_starved) state <= GNT_D;
          else if (iREN)          state <= GNT_I;
        end
        GNT_D: begin
          // A dropped request aborts the grant before RAM status is considered.
          if (!dreq) begin
            state <= IDLE;
          end else begin
            case (rs)
              ACCESS: begin
                state <= IDLE;
                if (!iREN)                    streak <= '0;
                else if (streak != STREAK_MAX) streak <= streak + 1'b1;
              end
              ERROR:   state <= IDLE;
              default: ;
            endcase
          end
        end
        GNT_I: begin
          if (!iREN) begin
            state <= IDLE;
          end else begin
            case (rs)
              ACCESS: begin
                state  <= IDLE;
                streak <= '0;
              end
              ERROR:   state <= IDLE;
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the granted requester to the RAM and decode wait/load/error.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramerr   = 1'b0;
    case (state)
      GNT_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        if (dreq) begin
          dwait  = (rs != ACCESS);
          ramerr = (rs == ERROR);
        end
      end
      GNT_I: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = ramload;
        if (iREN) begin
          iwait  = (rs != ACCESS);
          ramerr = (rs == ERROR);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with hand-computed expectations.
module tb_ram_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ramerr;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  int n_cmp = 0;
  int n_err = 0;

  ram_arbiter #(.MAX_D_STREAK(4), .STREAK_W(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int          dcnt;
  int          icnt;
  logic [31:0] seq;
  logic [31:0] both_en;

  initial begin
    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;

    // Reset values
    #2;
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramWEN", 32'(ramWEN), 32'd0);
    check("rst_iwait",  32'(iwait),  32'd1);
    check("rst_dwait",  32'(dwait),  32'd1);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramerr", 32'(ramerr), 32'd0);
    step(); step();
    nRST = 1'b1;

    // Reset asserted in the middle of a dcache write grant
    dWEN = 1'b1; daddr = 32'h40; dstore = 32'hAA; ramstate = RS_BUSY;
    #1 check("mid_idle_ramWEN", 32'(ramWEN), 32'd0);
    step();
    check("mid_gnt_ramWEN", 32'(ramWEN), 32'd1);
    check("mid_gnt_ramaddr", ramaddr, 32'h40);
    nRST = 1'b0;
    #1;
    check("mid_rst_ramWEN", 32'(ramWEN), 32'd0);
    check("mid_rst_dwait", 32'(dwait), 32'd1);
    check("mid_rst_iwait", 32'(iwait), 32'd1);
    dWEN = 1'b0;
    step();
    nRST = 1'b1;
    step();
    check("post_rst_ramREN", 32'(ramREN), 32'd0);
    check("post_rst_ramWEN", 32'(ramWEN), 32'd0);

    // Lone icache read, two BUSY cycles then ACCESS
    iREN = 1'b1; iaddr = 32'h100; ramstate = RS_BUSY;
    #1 check("ird_idle_ramREN", 32'(ramREN), 32'd0);
    step();
    check("ird_c1_ramREN", 32'(ramREN), 32'd1);
    check("ird_c1_ramaddr", ramaddr, 32'h100);
    check("ird_c1_iwait", 32'(iwait), 32'd1);
    step();
    check("ird_c2_ramREN", 32'(ramREN), 32'd1);
    check("ird_c2_iwait", 32'(iwait), 32'd1);
    step();
    ramstate = RS_ACCESS; ramload = 32'hDEADBEEF;
    #1;
    check("ird_c3_ramREN", 32'(ramREN), 32'd1);
    check("ird_c3_iwait", 32'(iwait), 32'd0);
    check("ird_c3_iload", iload, 32'hDEADBEEF);
    check("ird_c3_dwait", 32'(dwait), 32'd1);
    step();
    iREN = 1'b0; ramstate = RS_FREE;
    #1;
    check("ird_after_ramREN", 32'(ramREN), 32'd0);
    check("ird_after_iwait", 32'(iwait), 32'd1);
    check("ird_after_iload", iload, 32'h0);

    // Simultaneous dcache write and icache read: dcache first
    step();
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678;
    iREN = 1'b1; iaddr = 32'h300; ramstate = RS_BUSY;
    step();
    check("sim_d_ramWEN", 32'(ramWEN), 32'd1);
    check("sim_d_ramREN", 32'(ramREN), 32'd0);
    check("sim_d_ramstore", ramstore, 32'h12345678);
    check("sim_d_ramaddr", ramaddr, 32'h200);
    check("sim_d_iwait", 32'(iwait), 32'd1);
    step();
    ramstate = RS_ACCESS;
    #1 check("sim_d_dwait", 32'(dwait), 32'd0);
    step();
    dWEN = 1'b0; ramstate = RS_BUSY;
    #1;
    check("sim_gap_ramREN", 32'(ramREN), 32'd0);
    check("sim_gap_iwait", 32'(iwait), 32'd1);
    check("sim_gap_streak", 32'(dut.streak), 32'd1);
    step();
    check("sim_i_ramREN", 32'(ramREN), 32'd1);
    check("sim_i_ramaddr", ramaddr, 32'h300);
    ramstate = RS_ACCESS;
    #1 check("sim_i_iwait", 32'(iwait), 32'd0);
    step();
    iREN = 1'b0; ramstate = RS_FREE;
    #1 check("sim_end_streak", 32'(dut.streak), 32'd0);

    // Starvation: icache held while dcache issues 5 back-to-back reads
    step();
    dcnt = 0; icnt = 0; seq = '0; both_en = '0;
    daddr = 32'h400; ramstate = RS_ACCESS; ramload = 32'h55AA55AA;
    for (int k = 0; k < 60 && dcnt < 5; k++) begin
      dREN = (dcnt < 5);
      iREN = (icnt < 1);
      #1;
      if (ramREN && ramWEN) both_en++;
      if (!dwait) begin dcnt++; seq = {seq[30:0], 1'b1}; end
      if (!iwait) begin icnt++; seq = {seq[30:0], 1'b0}; end
      step();
    end
    dREN = 1'b0; iREN = 1'b0; ramstate = RS_FREE;
    #1;
    check("stv_dcount", 32'(dcnt), 32'd5);
    check("stv_icount", 32'(icnt), 32'd1);
    check("stv_order", seq, 32'h3D);
    check("stv_both_en", both_en, 32'd0);
    check("stv_streak", 32'(dut.streak), 32'd0);

    // ERROR during a dcache read grant
    step();
    dREN = 1'b1; daddr = 32'h500; ramstate = RS_BUSY;
    step();
    check("err_gnt_ramREN", 32'(ramREN), 32'd1);
    step();
    ramstate = RS_ERROR;
    #1;
    check("err_ramerr", 32'(ramerr), 32'd1);
    check("err_dwait", 32'(dwait), 32'd1);
    step();
    ramstate = RS_BUSY;
    #1;
    check("err_idle_ramerr", 32'(ramerr), 32'd0);
    check("err_idle_ramREN", 32'(ramREN), 32'd0);
    step();
    check("err_regrant_ramREN", 32'(ramREN), 32'd1);
    ramstate = RS_ACCESS; ramload = 32'hCAFEF00D;
    #1;
    check("err_done_dwait", 32'(dwait), 32'd0);
    check("err_done_dload", dload, 32'hCAFEF00D);
    step();
    dREN = 1'b0; ramstate = RS_FREE;

    // Abort: dREN dropped mid-grant
    step();
    dREN = 1'b1; daddr = 32'h600; ramstate = RS_BUSY;
    step();
    check("abt_gnt_ramREN", 32'(ramREN), 32'd1);
    step();
    dREN = 1'b0; ramstate = RS_ACCESS;
    #1;
    check("abt_ramREN", 32'(ramREN), 32'd0);
    check("abt_dwait", 32'(dwait), 32'd1);
    step();
    ramstate = RS_BUSY;
    #1;
    check("abt_idle_ramREN", 32'(ramREN), 32'd0);
    check("abt_streak", 32'(dut.streak), 32'd0);

    // Both dcache enables: write wins
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h700; dstore = 32'h0BADF00D;
    step();
    check("dual_ramWEN", 32'(ramWEN), 32'd1);
    check("dual_ramREN", 32'(ramREN), 32'd0);
    check("dual_ramstore", ramstore, 32'h0BADF00D);
    ramstate = RS_ACCESS;
    #1 check("dual_dwait", 32'(dwait), 32'd0);
    step();
    dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE;
    #1 check("dual_idle_ramWEN", 32'(ramWEN), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single RAM port between the instruction cache (read-only) and the data cache (read/write).
- Sits between caches and RAM.
- Grants one requester at a time and holds the grant until RAM completes the access.
- Dcache has priority; a starvation counter guarantees icache progress.

Parameters:
- MAX_D_STREAK, 4, consecutive dcache completions allowed while icache is waiting before icache is forced to win
- STREAK_W, 3, counter width; must hold MAX_D_STREAK

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  icache stall; low for exactly the completion cycle
- iload  out  32  icache read data, valid when iwait low
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  dcache stall; low for exactly the completion cycle
- dload  out  32  dcache read data, valid when dwait low
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR
- ramerr  out  1  one-cycle pulse when the granted access ends in ERROR

Behaviour:
- Reset (async, nRST low):
  - state=IDLE, streak=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0, ramerr=0.
  - iwait=dwait=1, iload=dload=0.
  - Outputs go to these values immediately, including mid-transfer.
- FSM states: IDLE, GNT_D, GNT_I; state is registered.
- IDLE:
  - RAM enables are 0; both wait outputs are 1.
  - Next state GNT_D if (dREN|dWEN) and !(iREN && streak==MAX_D_STREAK).
  - Else GNT_I if iREN.
  - Else stay IDLE.
- Latency:
  - A request seen in IDLE at edge n is granted at cycle n+1; the RAM enable is driven from n+1.
  - Minimum transfer time is 2 cycles.
- GNT_D:
  - ramaddr=daddr, ramstore=dstore, all combinational from dcache inputs.
  - ramWEN=dWEN; ramREN=dREN&!dWEN, so a write wins if both are asserted.
  - dload=ramload.
- GNT_I:
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0, iload=ramload.
- Completion (ramstate==ACCESS in a grant state):
  - The owner's wait output goes low combinationally in that cycle.
  - Next state is IDLE; one idle cycle always separates grants.
- ERROR in a grant state:
  - The wait output stays high and ramerr=1 for that cycle.
  - Next state is IDLE; the owner re-requests.
- FREE/BUSY in a grant state: hold the grant and the wait output.
- Owner drops its request mid-grant:
  - Abort; RAM enables drop combinationally and next state is IDLE.
  - No wait-low pulse; the streak is unchanged.
- Streak counter:
  - On a dcache completion with iREN=1: streak increments, saturating at MAX_D_STREAK.
  - On a dcache completion with iREN=0: streak clears.
  - On an icache completion: streak clears.
- A non-owner's wait output is always 1; its load output is 0.
- Requesters must hold address/data stable while their wait output is high.
- No RAM enable is ever asserted in IDLE. ramREN and ramWEN are never both 1.

Decomposition:
- Shared package (cpu_types_pkg): ramstate_t enum (FREE, BUSY, ACCESS, ERROR), word_t.
- Local arb_state_t enum {IDLE, GNT_D, GNT_I} defined in the module.
- No sub-module: a single FSM plus counter.

Test Plan:
- Reset mid-GNT_D write: assert nRST=0 while ramWEN=1 -> ramWEN falls without waiting for CLK; iwait=dwait=1; state=IDLE after release.
- Lone icache read: iREN=1, iaddr=0x100, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN=1 for 3 cycles; iwait low exactly on the ACCESS cycle with iload=0xDEADBEEF; then IDLE.
- Simultaneous dWEN and iREN: daddr=0x200, dstore=0x12345678 -> dcache granted first, ramWEN=1, ramstore=0x12345678; icache granted only after the dwait pulse plus one idle cycle.
- Starvation: iREN held high with 5 back-to-back dcache reads and MAX_D_STREAK=4 -> 4 dcache completions, then icache granted before the 5th dcache read; streak=0 afterwards.
- Error: ramstate=ERROR during GNT_D read -> ramerr pulses for 1 cycle; dwait stays 1; a re-request is regranted 1 cycle later.
- Abort and dual enable: dREN dropped during BUSY -> ramREN=0 the same cycle, no dwait pulse; dREN=dWEN=1 -> ramWEN=1, ramREN=0.
